// File: rtl/bit4_comparator_pkg.sv
// Shared definitions for the bit4_comparator block: default operand width,
// the three-way compare result encoding and a helper that turns that
// encoding into the greater/lesser/equal flag triple.
// Optional feature macro used by this slice: BIT4_COMPARATOR_SIGNED_EN
// (adds an sgn input selecting two's-complement compare).
package bit4_comparator_pkg;

    // Operand width the block is built and verified at.
    localparam int WIDTH_DEFAULT = 4;

    // Result of one compare; exactly one outcome is ever encoded.
    typedef enum logic [1:0] {
        EQ = 2'd0,
        GT = 2'd1,
        LT = 2'd2
    } cmp_result_e;

    // Flag triple {greater, lesser, equal}; one-hot by construction.
    function automatic logic [2:0] result_to_flags(input cmp_result_e res);
        logic [2:0] flags;
        flags = 3'b001;
        case (res)
            GT:      flags = 3'b100;
            LT:      flags = 3'b010;
            default: flags = 3'b001;
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/bit4_comparator_core.sv
// Purely combinational compare of a against b, producing the package
// result encoding. With BIT4_COMPARATOR_SIGNED_EN defined, sgn=1 treats the
// operands as two's complement; otherwise the compare is always unsigned.
module bit4_comparator_core
    import bit4_comparator_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef BIT4_COMPARATOR_SIGNED_EN
    input  logic             sgn,
`endif
    output cmp_result_e      result
);

    // Flipping the sign bit maps two's-complement order onto unsigned
    // order, so a single unsigned magnitude compare serves both modes.
    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;

    // Build the ordering keys (sign-bit flipped only in signed mode).
    always_comb begin
        a_key = a;
        b_key = b;
`ifdef BIT4_COMPARATOR_SIGNED_EN
        if (sgn) begin
            a_key = a ^ SIGN_MASK;
            b_key = b ^ SIGN_MASK;
        end
`endif
    end

    // Three-way compare of the keys into the result encoding.
    always_comb begin
        result = EQ;
        if (a_key > b_key) begin
            result = GT;
        end else if (a_key < b_key) begin
            result = LT;
        end
    end

endmodule

// File: rtl/bit4_comparator.sv
// Registered magnitude comparator. A request is presented with in_valid;
// the one-hot greater/lesser/equal result appears one cycle later together
// with a single-cycle out_valid pulse.
// Optional feature macro: BIT4_COMPARATOR_SIGNED_EN (adds sgn input).
//
// Handshake: valid-only, no ready in either direction. Every cycle with
// in_valid=1 is a request and is always accepted (no stall, no backpressure);
// out_valid=1 marks the cycle whose greater/lesser/equal belong to the request
// of the previous cycle. Between results the flags hold their last values.
module bit4_comparator
    import bit4_comparator_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef BIT4_COMPARATOR_SIGNED_EN
    input  logic             sgn,
`endif
    output logic             out_valid,
    output logic             greater,
    output logic             lesser,
    output logic             equal
);

    cmp_result_e cmp_result;
    logic [2:0]  next_flags;

    bit4_comparator_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (A),
        .b      (B),
`ifdef BIT4_COMPARATOR_SIGNED_EN
        .sgn    (sgn),
`endif
        .result (cmp_result)
    );

    assign next_flags = result_to_flags(cmp_result);

    // Valid pulse follows in_valid by one cycle; reset drops any in-flight one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    // Result flags load only on a request and otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            greater <= 1'b0;
            lesser  <= 1'b0;
            equal   <= 1'b0;
        end else if (in_valid) begin
            greater <= next_flags[2];
            lesser  <= next_flags[1];
            equal   <= next_flags[0];
        end
    end

endmodule

// File: tb/tb_bit4_comparator.sv
// Directed + random bench for bit4_comparator. Expected outputs come from an
// integer reference compare, are queued when a request is driven and popped
// one cycle later when the registered result appears.
module tb_bit4_comparator;
    import bit4_comparator_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         greater;
    logic         lesser;
    logic         equal;
`ifdef BIT4_COMPARATOR_SIGNED_EN
    logic         sgn;
`endif

    logic [3:0] exp_q[$];
    logic [2:0] model_flags;
    int         n_checks;
    int         n_errors;

    // Clock/reset block
    always #5 clk = ~clk;

    bit4_comparator #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
`ifdef BIT4_COMPARATOR_SIGNED_EN
        .sgn       (sgn),
`endif
        .out_valid (out_valid),
        .greater   (greater),
        .lesser    (lesser),
        .equal     (equal)
    );

    // Reference compare on integers: returns {greater, lesser, equal}.
    function automatic logic [2:0] ref_cmp(input logic [3:0] a, input logic [3:0] b,
                                           input logic s);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        if (s && ia >= 8) ia = ia - 16;
        if (s && ib >= 8) ib = ib - 16;
        return {ia > ib, ia < ib, ia == ib};
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Driver: present one cycle of stimulus, queue its expectation, then
    // compare the registered outputs just after the capturing edge.
    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic s, input string tag);
        logic [3:0] got;
        logic [3:0] exp;
        logic       s_eff;
        @(negedge clk);
        in_valid = v;
        A        = a;
        B        = b;
`ifdef BIT4_COMPARATOR_SIGNED_EN
        sgn   = s;
        s_eff = s;
`else
        s_eff = 1'b0;
`endif
        if (v) model_flags = ref_cmp(a, b, s_eff);
        exp_q.push_back({v, model_flags});
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        got = {out_valid, greater, lesser, equal};
        check(tag, got, exp);
        if (v) begin
            check({tag, "_onehot"}, {3'b000, $onehot({greater, lesser, equal})}, 4'b0001);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        model_flags = 3'b000;
        rst         = 1'b1;
        in_valid    = 1'b0;
        A           = '0;
        B           = '0;
`ifdef BIT4_COMPARATOR_SIGNED_EN
        sgn         = 1'b0;
`endif

        // Reset state, including a request presented while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check("reset_idle", {out_valid, greater, lesser, equal}, 4'b0000);
        @(negedge clk);
        in_valid = 1'b1;
        A        = 4'd9;
        B        = 4'd2;
        @(posedge clk);
        #1;
        check("reset_req_ignored", {out_valid, greater, lesser, equal}, 4'b0000);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;

        // First request after reset, then back-to-back directed cases.
        drive(1'b1, 4'd3,  4'd5,  1'b0, "a3_b5_lesser");
        drive(1'b1, 4'd9,  4'd2,  1'b0, "a9_b2_greater");
        drive(1'b1, 4'd7,  4'd7,  1'b0, "a7_b7_equal");
        drive(1'b1, 4'd0,  4'd15, 1'b0, "a0_b15_lesser");
        drive(1'b1, 4'd15, 4'd0,  1'b0, "a15_b0_greater");
        drive(1'b1, 4'd0,  4'd0,  1'b0, "a0_b0_equal");
        drive(1'b1, 4'd15, 4'd15, 1'b0, "a15_b15_equal");
        drive(1'b1, 4'd8,  4'd7,  1'b0, "a8_b7_unsigned");
        drive(1'b1, 4'd9,  4'd2,  1'b0, "a9_b2_again");

        // Idle cycles: out_valid drops, flags hold, A/B ignored.
        drive(1'b0, 4'd0,  4'd15, 1'b0, "idle_hold_1");
        drive(1'b0, 4'(($urandom_range(0, 15))), 4'(($urandom_range(0, 15))), 1'b0,
              "idle_hold_2");

        // Mid-operation reset: in-flight request is discarded immediately.
        drive(1'b1, 4'd9, 4'd2, 1'b0, "pre_reset_greater");
        @(negedge clk);
        in_valid = 1'b1;
        A        = 4'd3;
        B        = 4'd5;
        #2;
        rst = 1'b1;
        #1;
        check("reset_async_clear", {out_valid, greater, lesser, equal}, 4'b0000);
        @(posedge clk);
        #1;
        check("reset_held", {out_valid, greater, lesser, equal}, 4'b0000);
        @(negedge clk);
        rst         = 1'b0;
        in_valid    = 1'b0;
        model_flags = 3'b000;
        exp_q.delete();
        drive(1'b0, 4'd3, 4'd5, 1'b0, "no_stale_valid");
        drive(1'b1, 4'd3, 4'd5, 1'b0, "post_reset_first");

        // Random back-to-back traffic with occasional idles.
        for (int i = 0; i < 24; i++) begin
            drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'b0, "random_unsigned");
        end

`ifdef BIT4_COMPARATOR_SIGNED_EN
        // Signed mode cases.
        drive(1'b1, 4'd8,  4'd7, 1'b1, "signed_m8_7_lesser");
        drive(1'b1, 4'd8,  4'd7, 1'b0, "unsigned_8_7_greater");
        drive(1'b1, 4'hF,  4'h1, 1'b1, "signed_m1_1_lesser");
        drive(1'b1, 4'hF,  4'h8, 1'b1, "signed_m1_m8_greater");
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), "random_signed");
        end
`endif

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bit4_comparator.md
BIT4_COMPARATOR -- requirements
Module: bit4_comparator

Interface
REQ-001 Parameter: WIDTH, default 4, operand bit width; only 4 is verified.
REQ-002 Port: clk  input  1  rising-edge clock; the block's only clock.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  A/B qualify a compare request this cycle.
REQ-005 Port: A  input  WIDTH  first operand.
REQ-006 Port: B  input  WIDTH  second operand.
REQ-007 Port: out_valid  output  1  registered result valid pulse.
REQ-008 Port: greater  output  1  registered; A > B.
REQ-009 Port: lesser  output  1  registered; A < B.
REQ-010 Port: equal  output  1  registered; A == B.
REQ-011 Port (only with BIT4_COMPARATOR_SIGNED_EN): sgn  input  1  1 = two's-complement compare, 0 = unsigned.

Function
REQ-012 On each rising clk with in_valid=1, the block SHALL compare A against B and register greater/lesser/equal, with out_valid=1 on the following cycle (latency 1).
REQ-013 Exactly one of greater/lesser/equal SHALL be 1 whenever out_valid=1 (one-hot).
REQ-014 On a cycle with in_valid=0, the block SHALL drive out_valid=0 next cycle and hold greater/lesser/equal at their last values.
REQ-015 Back-to-back requests SHALL be accepted every cycle with no stall; there is no backpressure.
REQ-016 Default compare SHALL be unsigned: 0 < 15, 15 > 0, and 7 == 7.
REQ-017 Extremes SHALL be handled exactly: A=0/B=15 gives lesser, A=15/B=0 gives greater, A=B=0 gives equal.
REQ-018 X/Z on A/B SHALL not be resolved; behaviour with in_valid=0 SHALL be independent of A/B.

Reset
REQ-019 While rst=1, the block SHALL hold out_valid, greater, lesser and equal at 0, regardless of clk.
REQ-020 Reset asserted mid-operation SHALL discard the in-flight result; no out_valid follows the deassertion.
REQ-021 After rst deasserts, the first in_valid cycle SHALL produce a result one cycle later, normally.

Configuration
REQ-022 When BIT4_COMPARATOR_SIGNED_EN is defined, port sgn SHALL exist and sgn=1 SHALL compare A and B as two's complement, e.g. A=4'hF (-1), B=4'h1 gives lesser.
REQ-023 With BIT4_COMPARATOR_SIGNED_EN defined and sgn=0, results SHALL equal the unsigned results.
REQ-024 When BIT4_COMPARATOR_SIGNED_EN is undefined, there SHALL be no sgn port and all compares SHALL be unsigned.

Structure
REQ-025 Package bit4_comparator_pkg SHALL hold the WIDTH default constant and the result encoding type (GT, LT, EQ).
REQ-026 Sub-module bit4_comparator_core SHALL hold the purely combinational compare (A, B[, sgn] -> result encoding).
REQ-027 The top level SHALL contain only the valid register and the output registers.

Verification
REQ-028 A=3, B=5, in_valid=1 -> next cycle: out_valid=1, lesser=1, greater=0, equal=0.
REQ-029 A=9, B=2 -> greater=1; then A=7, B=7 -> equal=1, each driven on consecutive cycles without a gap.
REQ-030 A=0, B=15 -> lesser=1; A=15, B=0 -> greater=1, covering the boundary values.
REQ-031 Drive a valid request, assert rst mid-cycle, then release -> all outputs 0 immediately, with no stale out_valid.
REQ-032 in_valid=0 after the A=9, B=2 request -> out_valid=0 and greater stays 1 (held).
REQ-033 With BIT4_COMPARATOR_SIGNED_EN, sgn=1, A=8 (-8), B=7 -> lesser=1; the same operands with sgn=0 -> greater=1.
